glitch_cmd_sender: RTL and testbench
====================================

# glitch_cmd_sender

Host-side command initiator for the glitcher's UART configuration channel. It latches one set of glitch parameters on a start strobe and serializes them as a fixed 10-byte frame over UART. Optionally, it checks each byte's echo from the device before sending the next one. It sits in the test harness or a companion FPGA and drives the device's `uart_rx_i`.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz, passed to the UART sub-modules.
- `BAUD_RATE`, default 115200: line rate.
- `ECHO_TIMEOUT`, default 10_000: cycles to wait for each echo, about 2.3 byte times at the defaults.
- `clk` in, 1: the single clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start_i` in, 1: one-cycle request to send a frame.
- `delay_i` in, 16: glitch delay.
- `width_i` in, 8: pulse width.
- `num_pulses_i` in, 8: pulse count.
- `pulse_spacing_i` in, 16: spacing between pulses.
- `pulse_en_i` in, 1: pulse enable.
- `uart_tx_o` out, 1: serial output to the device.
- `uart_rx_i` in, 1: serial input carrying echoes from the device.
- `busy_o` out, 1: high from the start-accept cycle until done.
- `done_o` out, 1: one-cycle pulse at the end of a frame, successful or aborted.
- `error_o` out, 1: qualifies `done_o`; high when the frame aborted.
- `err_code_o` out, 2: 00 none, 01 echo mismatch, 10 echo timeout. Held until the next start.

## Operation
- Frame format, in byte order:
  - 0xA5 (sync)
  - 0x01 (CMD_SET_CFG)
  - delay[15:8], delay[7:0]
  - width
  - num_pulses
  - spacing[15:8], spacing[7:0]
  - {7'b0, pulse_en}
  - checksum = XOR of bytes 1 through 8
- All inputs are latched on the cycle `start_i` is accepted. Later input changes do not affect the frame in flight.
- `start_i` is accepted only in IDLE. It is ignored while `busy_o` is high.
- States:
  - IDLE: `start_i` → LOAD.
  - LOAD: build the frame, clear byte index and `err_code_o` → SEND.
  - SEND: when the UART transmitter is not busy, pulse tx enable for one cycle with frame[idx] → WAIT.
  - WAIT:
    - With echo check: an rx byte equal to frame[idx] → NEXT. A different rx byte → ABORT(01). Timeout counter reaching `ECHO_TIMEOUT` → ABORT(10).
    - Without echo check: the transmitter goes busy, then not busy → NEXT.
  - NEXT: idx==9 → DONE, otherwise idx+1 → SEND.
  - DONE / ABORT: pulse `done_o`, set `error_o` per the outcome → IDLE.
- The timeout counter clears on every SEND. It is 32-bit and saturating.
- Received rx bytes outside WAIT are discarded.
- On abort, remaining bytes are not sent. A byte already being shifted out completes on the line.
- Reset mid-frame: all state returns to IDLE immediately and no `done_o` is produced. `uart_tx_o` returns high; a partial byte is truncated.

## Timing
- Reset values:
  - `busy_o`=0, `done_o`=0, `error_o`=0, `err_code_o`=00.
  - `uart_tx_o`=1.
  - State IDLE, idx=0.
- `start_i` at cycle T:
  - `busy_o`=1 at T+1.
  - First tx enable pulse at T+3 if the transmitter is idle.
- Tx enable is never asserted on two consecutive cycles. The WAIT entry guarantees this, since transmitter busy lags enable by one cycle.
- `done_o` occurs 2 cycles after the last echo `data_valid` (echo check on), or after the transmitter's busy falls (echo check off).
- `busy_o` falls in the same cycle `done_o` pulses.
- A new `start_i` is accepted the cycle after `done_o`.

## Configuration
- Macro `GLITCH_CMD_ECHO_CHECK_EN`.
- Defined:
  - A `uart_rx` instance is present and per-byte echo compare with timeout is active.
  - `err_code_o` can take 01 or 10.
- Undefined:
  - No `uart_rx` is instantiated and `uart_rx_i` is unused.
  - Bytes are paced only by transmitter busy.
  - `error_o` is always 0 and `err_code_o` is always 00.

## Structure
- Package `glitch_cmd_pkg` holds:
  - `SYNC_BYTE`=8'hA5 and `CMD_SET_CFG`=8'h01.
  - `FRAME_LEN`=10.
  - Error code constants.
  - The state enum.
- The existing `uart_tx` is instantiated, plus `uart_rx` under the macro. No new sub-module: frame building is a 10-entry byte mux inside this block.

## Test plan
- Basic frame: delay=0x1234, width=0x10, num=3, spacing=0x0100, en=1, loopback echo model → line carries A5 01 12 34 10 03 01 00 01 34; one `done_o` with `error_o`=0.
- Echo corruption: echo of byte 4 returned as 0x11 → `done_o`+`error_o` with `err_code_o`=01; bytes 5–9 never transmitted.
- No echo: rx held high → abort with `err_code_o`=10 about `ECHO_TIMEOUT` cycles after byte 0's tx enable.
- `start_i` pulsed at cycle 500 of an active frame → ignored; exactly 10 bytes sent; the latched values are unchanged even if the inputs change after the start.
- `rst_n` asserted during byte 3 → `busy_o`=0 and `uart_tx_o`=1 immediately, no `done_o`; a next start sends a full correct frame.
- Build without the macro → same byte stream as the basic frame test with rx tied high, `error_o` never asserted.

Source files
------------

// File: rtl/glitch_cmd_pkg.sv
// Shared constants, error codes and FSM state encoding for the glitch
// command sender (frame layout, sync/command bytes, abort reasons).
package glitch_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_SET_CFG = 8'h01;

  localparam int         FRAME_LEN = 10;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_ABORT
  } state_e;

  // XOR of frame bytes 1..8 (command byte through the enable byte).
  function automatic logic [7:0] frame_checksum(
    input logic [15:0] delay,
    input logic [7:0]  width,
    input logic [7:0]  num_pulses,
    input logic [15:0] spacing,
    input logic        pulse_en
  );
    return CMD_SET_CFG ^ delay[15:8] ^ delay[7:0] ^ width ^ num_pulses ^
           spacing[15:8] ^ spacing[7:0] ^ {7'b0, pulse_en};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver used for echo checking. Only built when
// GLITCH_CMD_ECHO_CHECK_EN is defined. valid_o pulses one cycle per
// byte whose stop bit was seen high.
`ifdef GLITCH_CMD_ECHO_CHECK_EN
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int               CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        st_q;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Start-bit qualification at mid-bit, then sample each bit at its centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (st_q)
        RX_IDLE: begin
          if (!sync2_q) begin
            st_q  <= RX_START;
            cnt_q <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            st_q  <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_q == 3'd7) st_q <= RX_STOP;
            else               bit_q <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            st_q  <= RX_IDLE;
            if (sync2_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= RX_IDLE;
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule
`endif

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A one-cycle tx_en_i while idle starts a byte;
// busy_o rises the cycle after the enable and falls after the stop bit.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int                CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int                CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

  logic             busy_q;
  logic             tx_q;
  logic [8:0]       shift_q;
  logic [3:0]       bit_q;
  logic [CNT_W-1:0] cnt_q;

  // Bit timer and shifter: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      shift_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else if (!busy_q) begin
      if (tx_en_i) begin
        busy_q  <= 1'b1;
        tx_q    <= 1'b0;
        shift_q <= {1'b1, tx_data_i};
        bit_q   <= '0;
        cnt_q   <= '0;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
      end else begin
        tx_q    <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
        bit_q   <= bit_q + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/glitch_cmd_sender.sv
// Host-side glitch configuration sender: latches the parameters on a start
// strobe and serializes a 10-byte SET_CFG frame over UART.
// Define GLITCH_CMD_ECHO_CHECK_EN to add a receiver that compares each
// byte's echo (with timeout) before sending the next one; otherwise bytes
// are paced by the transmitter alone and no error is ever reported.
module glitch_cmd_sender
  import glitch_cmd_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int ECHO_TIMEOUT = 10_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic        pulse_en_i,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] dly_q, dly_d;
  logic [7:0]  wid_q, wid_d;
  logic [7:0]  npulse_q, npulse_d;
  logic [15:0] spc_q, spc_d;
  logic        pen_q, pen_d;
  logic [7:0]  csum_q, csum_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        tx_busy;
  logic [7:0]  frame_byte;

`ifdef GLITCH_CMD_ECHO_CHECK_EN
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(ECHO_TIMEOUT);

  logic [31:0] timeout_q, timeout_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  rx_data;
  logic        rx_valid;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_i    (uart_rx_i),
    .data_o  (rx_data),
    .valid_o (rx_valid)
  );
`else
  logic        seen_busy_q, seen_busy_d;
  logic        unused_rx;
  logic [31:0] unused_timeout;

  assign unused_rx      = uart_rx_i;
  assign unused_timeout = 32'(ECHO_TIMEOUT);
`endif

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en_i   (tx_en_q),
    .tx_data_i (tx_data_q),
    .tx_o      (uart_tx_o),
    .busy_o    (tx_busy)
  );

  // Frame byte selected by the current index from the latched parameters.
  always_comb begin
    frame_byte = 8'h00;
    unique case (idx_q)
      4'd0:    frame_byte = SYNC_BYTE;
      4'd1:    frame_byte = CMD_SET_CFG;
      4'd2:    frame_byte = dly_q[15:8];
      4'd3:    frame_byte = dly_q[7:0];
      4'd4:    frame_byte = wid_q;
      4'd5:    frame_byte = npulse_q;
      4'd6:    frame_byte = spc_q[15:8];
      4'd7:    frame_byte = spc_q[7:0];
      4'd8:    frame_byte = {7'b0, pen_q};
      4'd9:    frame_byte = csum_q;
      default: frame_byte = 8'h00;
    endcase
  end

  // Next-state logic: latch, send one byte, wait for pacing/echo, advance.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dly_d     = dly_q;
    wid_d     = wid_q;
    npulse_d  = npulse_q;
    spc_d     = spc_q;
    pen_d     = pen_q;
    csum_d    = csum_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
`ifdef GLITCH_CMD_ECHO_CHECK_EN
    timeout_d  = timeout_q;
    err_code_d = err_code_q;
`else
    seen_busy_d = seen_busy_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dly_d    = delay_i;
          wid_d    = width_i;
          npulse_d = num_pulses_i;
          spc_d    = pulse_spacing_i;
          pen_d    = pulse_en_i;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d   = '0;
        csum_d  = frame_checksum(dly_q, wid_q, npulse_q, spc_q, pen_q);
`ifdef GLITCH_CMD_ECHO_CHECK_EN
        err_code_d = ERR_NONE;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
`ifdef GLITCH_CMD_ECHO_CHECK_EN
        timeout_d = '0;
`else
        seen_busy_d = 1'b0;
`endif
        if (!tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = frame_byte;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
`ifdef GLITCH_CMD_ECHO_CHECK_EN
        if (rx_valid) begin
          if (rx_data == frame_byte) begin
            state_d = ST_NEXT;
          end else begin
            err_code_d = ERR_MISMATCH;
            state_d    = ST_ABORT;
          end
        end else if (timeout_q >= TIMEOUT_LIMIT) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_ABORT;
        end else if (timeout_q != 32'hFFFF_FFFF) begin
          timeout_d = timeout_q + 32'd1;
        end
`else
        if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          state_d = ST_NEXT;
        end
`endif
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_SEND;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dly_q     <= '0;
      wid_q     <= '0;
      npulse_q  <= '0;
      spc_q     <= '0;
      pen_q     <= 1'b0;
      csum_q    <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
`ifdef GLITCH_CMD_ECHO_CHECK_EN
      timeout_q  <= '0;
      err_code_q <= ERR_NONE;
`else
      seen_busy_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      wid_q     <= wid_d;
      npulse_q  <= npulse_d;
      spc_q     <= spc_d;
      pen_q     <= pen_d;
      csum_q    <= csum_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
`ifdef GLITCH_CMD_ECHO_CHECK_EN
      timeout_q  <= timeout_d;
      err_code_q <= err_code_d;
`else
      seen_busy_q <= seen_busy_d;
`endif
    end
  end

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ABORT);
  assign done_o = (state_q == ST_DONE) || (state_q == ST_ABORT);

`ifdef GLITCH_CMD_ECHO_CHECK_EN
  assign error_o    = (state_q == ST_ABORT);
  assign err_code_o = err_code_q;
`else
  assign error_o    = 1'b0;
  assign err_code_o = ERR_NONE;
`endif

endmodule

// File: tb/tb_glitch_cmd_sender.sv
// Self-checking bench for glitch_cmd_sender: table of parameter sets with
// hand-computed frames, plus directed sequences for start-while-busy,
// mid-frame reset and (with GLITCH_CMD_ECHO_CHECK_EN) echo mismatch/timeout.
module tb_glitch_cmd_sender;

  localparam int CLK_FREQ     = 1_000_000;
  localparam int BAUD_RATE    = 100_000;
  localparam int CPB          = 10;
  localparam int ECHO_TIMEOUT = 400;

  typedef struct {
    logic [15:0]     delay;
    logic [7:0]      width;
    logic [7:0]      num;
    logic [15:0]     spacing;
    logic            en;
    logic [0:9][7:0] frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] delay_i = '0;
  logic [7:0]  width_i = '0;
  logic [7:0]  num_pulses_i = '0;
  logic [15:0] pulse_spacing_i = '0;
  logic        pulse_en_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  err_code_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_count = 0;
  int err_seen = 0;
  int echo_mode = 0;
  int last_start_cyc = 0;
  int mon_start = 0;
  logic [7:0] mon_byte;
  logic [7:0] echo_byte;
  logic [7:0] line_q[$];
  event echo_ev;
  vec_t vecs[4];

  glitch_cmd_sender #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .ECHO_TIMEOUT (ECHO_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .delay_i         (delay_i),
    .width_i         (width_i),
    .num_pulses_i    (num_pulses_i),
    .pulse_spacing_i (pulse_spacing_i),
    .pulse_en_i      (pulse_en_i),
    .uart_tx_o       (uart_tx_o),
    .uart_rx_i       (uart_rx_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .err_code_o      (err_code_o)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Count done and error pulses on the falling edge.
  always @(negedge clk) begin
    if (done_o === 1'b1) done_count++;
    if (error_o === 1'b1) err_seen++;
  end

  // Decode bytes from the serial line and optionally schedule an echo.
  initial begin : line_monitor
    forever begin
      @(negedge uart_tx_o);
      #1;
      mon_start = cyc;
      repeat (CPB / 2) @(posedge clk);
      if (uart_tx_o == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          mon_byte[i] = uart_tx_o;
        end
        repeat (CPB) @(posedge clk);
        line_q.push_back(mon_byte);
        last_start_cyc = mon_start;
        if (echo_mode != 0) begin
          echo_byte = (echo_mode == 2 && line_q.size() == 5) ? 8'h11 : mon_byte;
          -> echo_ev;
        end
      end
    end
  end

  // Device echo model: re-serializes each decoded byte onto uart_rx_i.
  initial begin : echo_model
    forever begin
      @(echo_ev);
      #1;
      uart_rx_i = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        uart_rx_i = echo_byte[i];
        repeat (CPB) @(posedge clk);
        #1;
      end
      uart_rx_i = 1'b1;
      repeat (CPB) @(posedge clk);
    end
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    delay_i         = v.delay;
    width_i         = v.width;
    num_pulses_i    = v.num;
    pulse_spacing_i = v.spacing;
    pulse_en_i      = v.en;
    start_i         = 1'b1;
    @(posedge clk); #1;
    start_i         = 1'b0;
  endtask

  task automatic waitDone(input string name, output int dcyc);
    int n;
    n = 0;
    dcyc = -1;
    while (n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (done_o === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s done wait: got no done_o, expected done_o within 4000 cycles", name);
    end
  endtask

  task automatic checkFrame(input string name, input vec_t v, input int d0);
    @(negedge clk); #1;
    checkOutput({name, " done count"}, 32'(done_count - d0), 1);
    checkOutput({name, " byte count"}, 32'(line_q.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < line_q.size())
        checkOutput($sformatf("%s byte%0d", name, i), 32'(line_q[i]), 32'(v.frame[i]));
    end
  endtask

  task automatic runFrame(input vec_t v, input string name);
    int d0;
    int d;
    line_q.delete();
    d0 = done_count;
    applyStimulus(v);
    checkOutput({name, " busy at T+1"}, 32'(busy_o), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput({name, " line idle at T+3"}, 32'(uart_tx_o), 1);
    @(posedge clk); #1;
    checkOutput({name, " start bit at T+4"}, 32'(uart_tx_o), 0);
    waitDone(name, d);
    if (d >= 0) begin
      checkOutput({name, " busy at done"}, 32'(busy_o), 0);
      checkOutput({name, " error at done"}, 32'(error_o), 0);
      checkOutput({name, " err_code at done"}, 32'(err_code_o), 0);
`ifndef GLITCH_CMD_ECHO_CHECK_EN
      checkOutput({name, " done latency from last start bit"}, 32'(d - last_start_cyc), 32'(10 * CPB + 2));
`endif
    end
    checkFrame(name, v, d0);
  endtask

  initial begin : main
    int d0;
    int d;
    int t;
    int n;

    vecs[0] = '{16'h1234, 8'h10, 8'h03, 16'h0100, 1'b1,
                {8'hA5, 8'h01, 8'h12, 8'h34, 8'h10, 8'h03, 8'h01, 8'h00, 8'h01, 8'h34}};
    vecs[1] = '{16'h0000, 8'h00, 8'h00, 16'h0000, 1'b0,
                {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF, 1'b1,
                {8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00}};
    vecs[3] = '{16'hABCD, 8'h5A, 8'hC3, 16'h8001, 1'b0,
                {8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h5A, 8'hC3, 8'h80, 8'h01, 8'h00, 8'h7F}};

`ifdef GLITCH_CMD_ECHO_CHECK_EN
    echo_mode = 1;
`else
    echo_mode = 0;
`endif

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy_o), 0);
    checkOutput("reset done", 32'(done_o), 0);
    checkOutput("reset error", 32'(error_o), 0);
    checkOutput("reset err_code", 32'(err_code_o), 0);
    checkOutput("reset tx line", 32'(uart_tx_o), 1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table of parameter sets, sent back to back.
    for (int i = 0; i < 4; i++)
      runFrame(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed mid-frame with changed inputs must be ignored.
    line_q.delete();
    d0 = done_count;
    applyStimulus(vecs[0]);
    repeat (499) @(posedge clk);
    #1;
    checkOutput("ignored start busy", 32'(busy_o), 1);
    delay_i         = 16'hDEAD;
    width_i         = 8'hBE;
    num_pulses_i    = 8'hEF;
    pulse_spacing_i = 16'h5555;
    pulse_en_i      = 1'b0;
    start_i         = 1'b1;
    @(posedge clk); #1;
    start_i         = 1'b0;
    waitDone("ignored start", d);
    checkFrame("ignored start", vecs[0], d0);

    // Reset asserted while byte 3 is on the line.
    line_q.delete();
    d0 = done_count;
    applyStimulus(vecs[3]);
    n = 0;
    while (line_q.size() < 3 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    n = 0;
    while (uart_tx_o !== 1'b0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("byte3 start seen", 32'(uart_tx_o), 0);
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-frame reset busy", 32'(busy_o), 0);
    checkOutput("mid-frame reset tx line", 32'(uart_tx_o), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    checkOutput("no done after reset", 32'(done_count - d0), 0);
    runFrame(vecs[0], "after reset");

`ifdef GLITCH_CMD_ECHO_CHECK_EN
    // No echo at all: abort with timeout after byte 0.
    echo_mode = 0;
    line_q.delete();
    d0 = done_count;
    applyStimulus(vecs[0]);
    t = cyc - 1;
    waitDone("echo timeout", d);
    if (d >= 0) begin
      checkOutput("timeout latency", 32'(d - t), 32'(ECHO_TIMEOUT + 4));
      checkOutput("timeout error", 32'(error_o), 1);
      checkOutput("timeout err_code", 32'(err_code_o), 2);
      checkOutput("timeout busy", 32'(busy_o), 0);
    end
    repeat (150) @(posedge clk);
    #1;
    checkOutput("timeout bytes sent", 32'(line_q.size()), 1);
    checkOutput("timeout done count", 32'(done_count - d0), 1);

    // Corrupted echo of byte 4: abort with mismatch, bytes 5..9 never sent.
    echo_mode = 2;
    line_q.delete();
    applyStimulus(vecs[0]);
    waitDone("echo mismatch", d);
    if (d >= 0) begin
      checkOutput("mismatch error", 32'(error_o), 1);
      checkOutput("mismatch err_code", 32'(err_code_o), 1);
    end
    repeat (300) @(posedge clk);
    #1;
    checkOutput("mismatch bytes sent", 32'(line_q.size()), 5);
    if (line_q.size() >= 5)
      checkOutput("mismatch last byte", 32'(line_q[4]), 32'h10);
    checkOutput("err_code held", 32'(err_code_o), 1);
    echo_mode = 1;
    runFrame(vecs[0], "after mismatch");
`else
    checkOutput("error_o never asserted", 32'(err_seen), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
